// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: tracks destinations of in-flight long-latency ops and stalls ID on RAW/WAW.
// Optional: define SCOREBOARD_BYPASS_EN to drop the stall in the completion cycle (core forwards data).

module wb_sb_file #(
  parameter bit HARD_ZERO = 1'b0,
  parameter int NUM_SRC   = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        set_en,
  input  logic [4:0]                  set_rd,
  input  logic                        clr_en,
  input  logic [4:0]                  clr_rd,
  input  logic [NUM_SRC-1:0][4:0]     src,
  input  logic                        wr_en,
  input  logic [4:0]                  wr_rd,
  output logic [31:0]                 pending,
  output logic                        tgt_busy,
  output logic                        clr_stale,
  output logic                        hit
);
  logic [31:0]        clr_mask, nxt, cmp;
  logic [NUM_SRC-1:0] src_hit;

  assign clr_mask = clr_en ? (32'd1 << clr_rd) : 32'd0;

  always_comb begin
    nxt = pending & ~clr_mask;
    if (set_en) nxt[set_rd] = 1'b1;
    if (HARD_ZERO) nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pending <= '0;
    else if (flush) pending <= '0;
    else            pending <= nxt;
  end

  // Issue may reuse a register whose completion lands this same cycle.
  assign tgt_busy  = pending[set_rd] && !(clr_en && clr_rd == set_rd);
  assign clr_stale = !pending[clr_rd];

`ifdef SCOREBOARD_BYPASS_EN
  assign cmp = pending & ~(flush ? 32'd0 : clr_mask);
`else
  assign cmp = pending;
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_hit[i] = cmp[src[i]];
  end

  assign hit = (|src_hit) || (wr_en && cmp[wr_rd]);
endmodule

module wb_scoreboard #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic        issue_is_fp,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        cmpl_valid,
  input  logic        cmpl_is_fp,
  input  logic [4:0]  cmpl_rd,
  input  logic        flush,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_fp_rs1,
  input  logic [4:0]  id_fp_rs2,
  input  logic [4:0]  id_fp_rs3,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_is_fp,
  input  logic        id_reg_write,
  output logic        stall_id,
  output logic [31:0] int_pending,
  output logic [31:0] fp_pending,
  output logic [2:0]  outstanding,
  output logic        proto_err
);
  localparam logic [2:0] MAX_C = 3'(MAX_OUTSTANDING);

  logic              accept, cmpl_ok, dec, bad_cmpl;
  logic [1:0]        tgt_busy, clr_stale, hit;
  logic [1:0][31:0]  pend;
  logic [1:0][2:0][4:0] src;

  // File 0 is integer (x0 hardwired, two sources), file 1 is FP.
  assign src[0] = {5'd0, id_rs2, id_rs1};
  assign src[1] = {id_fp_rs3, id_fp_rs2, id_fp_rs1};

  for (genvar f = 0; f < 2; f++) begin : g_file
    localparam logic IS_FP = 1'(f);
    wb_sb_file #(.HARD_ZERO(f == 0), .NUM_SRC(3)) u_file (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .set_en    (accept && issue_is_fp == IS_FP),
      .set_rd    (issue_rd),
      .clr_en    (cmpl_valid && cmpl_is_fp == IS_FP),
      .clr_rd    (cmpl_rd),
      .src       (src[f]),
      .wr_en     (id_reg_write && id_rd_is_fp == IS_FP),
      .wr_rd     (id_rd),
      .pending   (pend[f]),
      .tgt_busy  (tgt_busy[f]),
      .clr_stale (clr_stale[f]),
      .hit       (hit[f])
    );
  end

  assign issue_ready = (outstanding < MAX_C || cmpl_valid) && !tgt_busy[issue_is_fp];
  assign accept      = issue_valid && issue_ready && !flush;
  assign cmpl_ok     = cmpl_valid && !flush;
  assign dec         = cmpl_ok && (outstanding != 3'd0);
  assign bad_cmpl    = cmpl_ok && clr_stale[cmpl_is_fp] && (cmpl_is_fp || cmpl_rd != 5'd0);

  assign stall_id    = |hit;
  assign int_pending = pend[0];
  assign fp_pending  = pend[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              outstanding <= 3'd0;
    else if (flush)            outstanding <= 3'd0;
    else if (accept && !dec)   outstanding <= outstanding + 3'd1;
    else if (!accept && dec)   outstanding <= outstanding - 3'd1;
  end

  // Sticky until reset; a flush does not forgive a bogus completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      proto_err <= 1'b0;
    else if (bad_cmpl) proto_err <= 1'b1;
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios with literal checks, then random traffic
// compared every cycle against a set-of-pending-registers model.

module tb_wb_scoreboard;
  localparam int MAXO = 2;

  logic        clk, reset_n;
  logic        issue_valid, issue_is_fp, cmpl_valid, cmpl_is_fp, flush;
  logic [4:0]  issue_rd, cmpl_rd, id_rs1, id_rs2, id_fp_rs1, id_fp_rs2, id_fp_rs3, id_rd;
  logic        id_rd_is_fp, id_reg_write;
  logic        issue_ready, stall_id, proto_err;
  logic [31:0] int_pending, fp_pending;
  logic [2:0]  outstanding;

  wb_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_is_fp(issue_is_fp), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .cmpl_valid(cmpl_valid), .cmpl_is_fp(cmpl_is_fp), .cmpl_rd(cmpl_rd),
    .flush(flush),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_fp_rs1(id_fp_rs1), .id_fp_rs2(id_fp_rs2), .id_fp_rs3(id_fp_rs3),
    .id_rd(id_rd), .id_rd_is_fp(id_rd_is_fp), .id_reg_write(id_reg_write),
    .stall_id(stall_id), .int_pending(int_pending), .fp_pending(fp_pending),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pending sets per file, in-flight count, sticky error flag.
  bit [31:0] m_int, m_fp;
  int        m_cnt;
  bit        m_perr;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pend(input bit fp, input logic [4:0] r);
    return fp ? m_fp[r] : (r != 0 && m_int[r]);
  endfunction

  function automatic bit m_seen(input bit fp, input logic [4:0] r);
    bit clr_now = cmpl_valid && !flush && cmpl_is_fp == fp && cmpl_rd == r;
    return m_pend(fp, r) && !(BYP && clr_now);
  endfunction

  function automatic bit m_ready();
    bit same = cmpl_valid && cmpl_is_fp == issue_is_fp && cmpl_rd == issue_rd;
    if (!reset_n) return 1'b1;
    return (m_cnt < MAXO || cmpl_valid) && !(m_pend(issue_is_fp, issue_rd) && !same);
  endfunction

  function automatic bit m_stall();
    if (!reset_n) return 1'b0;
    return m_seen(0, id_rs1) || m_seen(0, id_rs2) || m_seen(1, id_fp_rs1) ||
           m_seen(1, id_fp_rs2) || m_seen(1, id_fp_rs3) ||
           (id_reg_write && m_seen(id_rd_is_fp, id_rd));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_int = 0; m_fp = 0; m_cnt = 0; m_perr = 0;
    end else if (flush) begin
      m_int = 0; m_fp = 0; m_cnt = 0;
    end else begin
      bit acc, dec;
      acc = issue_valid && m_ready();
      dec = cmpl_valid && m_cnt > 0;
      if (cmpl_valid) begin
        if (!m_pend(cmpl_is_fp, cmpl_rd) && (cmpl_is_fp || cmpl_rd != 0)) m_perr = 1;
        if (cmpl_is_fp) m_fp[cmpl_rd] = 0; else m_int[cmpl_rd] = 0;
      end
      if (acc) begin
        if (issue_is_fp) m_fp[issue_rd] = 1;
        else if (issue_rd != 0) m_int[issue_rd] = 1;
      end
      m_cnt = m_cnt + int'(acc) - int'(dec);
    end
  end

  // Every cycle: DUT against model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("int_pending", int_pending, m_int);
    chk("fp_pending", fp_pending, m_fp);
    chk("outstanding", 32'(outstanding), 32'(m_cnt));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    chk("issue_ready", 32'(issue_ready), 32'(m_ready()));
    chk("stall_id", 32'(stall_id), 32'(m_stall()));
  end

  task automatic idle();
    issue_valid = 0; issue_is_fp = 0; issue_rd = 0;
    cmpl_valid = 0; cmpl_is_fp = 0; cmpl_rd = 0; flush = 0;
    id_rs1 = 0; id_rs2 = 0; id_fp_rs1 = 0; id_fp_rs2 = 0; id_fp_rs3 = 0;
    id_rd = 0; id_rd_is_fp = 0; id_reg_write = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit fp, input logic [4:0] r);
    issue_valid = 1; issue_is_fp = fp; issue_rd = r;
  endtask

  task automatic cmpl(input bit fp, input logic [4:0] r);
    cmpl_valid = 1; cmpl_is_fp = fp; cmpl_rd = r;
  endtask

  initial begin
    idle();
    reset_n = 0;
    issue(0, 5'd9);
    #1;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    cyc(); cyc();
    idle();
    chk("rst_int", int_pending, 32'd0);
    chk("rst_out", 32'(outstanding), 32'd0);
    reset_n = 1;
    cyc();

    // Issue x5, RAW on rs2, then complete.
    issue(0, 5'd5); cyc(); idle();
    chk("x5_pend", int_pending, 32'h20);
    chk("x5_out", 32'(outstanding), 32'd1);
    id_rs2 = 5'd5; #1;
    chk("x5_raw", 32'(stall_id), 32'd1);
    cmpl(0, 5'd5); #1;
    chk("x5_cmpl_stall", 32'(stall_id), BYP ? 32'd0 : 32'd1);
    cyc(); cmpl_valid = 0; #1;
    chk("x5_clr", int_pending, 32'd0);
    chk("x5_release", 32'(stall_id), 32'd0);
    idle();

    // f3 and x3 fill the scoreboard.
    issue(1, 5'd3); cyc(); issue(0, 5'd3); cyc();
    issue(0, 5'd4); #1;
    chk("full_ready", 32'(issue_ready), 32'd0);
    chk("full_fp", fp_pending, 32'h8);
    chk("full_int", int_pending, 32'h8);
    chk("full_out", 32'(outstanding), 32'd2);
    idle(); id_fp_rs3 = 5'd3; #1;
    chk("f3_raw", 32'(stall_id), 32'd1);
    id_fp_rs3 = 0; id_rs1 = 5'd4; #1;
    chk("x4_nostall", 32'(stall_id), 32'd0);
    idle();

    // Full with completion x3 and issue x9 in the same cycle.
    cmpl(0, 5'd3); issue(0, 5'd9); #1;
    chk("swap_ready", 32'(issue_ready), 32'd1);
    cyc(); idle();
    chk("swap_out", 32'(outstanding), 32'd2);
    chk("swap_int", int_pending, 32'h200);
    chk("swap_fp", fp_pending, 32'h8);
    cmpl(1, 5'd3); cyc(); cmpl(0, 5'd9); cyc(); idle();
    chk("drain_out", 32'(outstanding), 32'd0);

    // x0 counts but sets no bit; its completion is legal.
    issue(0, 5'd0); cyc(); idle();
    chk("x0_int", int_pending, 32'd0);
    chk("x0_out", 32'(outstanding), 32'd1);
    cmpl(0, 5'd0); cyc(); idle();
    chk("x0_cmpl_out", 32'(outstanding), 32'd0);
    chk("x0_perr", 32'(proto_err), 32'd0);

    // Flush wipes tracking; a late completion is a protocol error.
    issue(0, 5'd7); cyc(); issue(1, 5'd1); cyc();
    issue(0, 5'd8); flush = 1; cyc(); idle();
    chk("flush_int", int_pending, 32'd0);
    chk("flush_fp", fp_pending, 32'd0);
    chk("flush_out", 32'(outstanding), 32'd0);
    cmpl(0, 5'd8); cyc(); idle();
    chk("perr_set", 32'(proto_err), 32'd1);
    flush = 1; cyc(); idle(); cyc();
    chk("perr_sticky", 32'(proto_err), 32'd1);

    // WAW on x12, then asynchronous reset mid-stall.
    issue(0, 5'd12); cyc(); idle();
    id_reg_write = 1; id_rd = 5'd12; #1;
    chk("waw_int", 32'(stall_id), 32'd1);
    id_rd_is_fp = 1; #1;
    chk("waw_fp", 32'(stall_id), 32'd0);
    id_rd_is_fp = 0; #1;
    reset_n = 0; #1;
    chk("arst_stall", 32'(stall_id), 32'd0);
    chk("arst_int", int_pending, 32'd0);
    chk("arst_out", 32'(outstanding), 32'd0);
    chk("arst_perr", 32'(proto_err), 32'd0);
    chk("arst_ready", 32'(issue_ready), 32'd1);
    cyc(); reset_n = 1; idle(); cyc();

    // Random traffic on a small register window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      issue_valid  = ($urandom_range(0, 1) == 1);
      issue_is_fp  = 1'($urandom);
      issue_rd     = 5'($urandom_range(0, 7));
      cmpl_valid   = ($urandom_range(0, 2) == 0);
      cmpl_is_fp   = 1'($urandom);
      cmpl_rd      = 5'($urandom_range(0, 7));
      flush        = ($urandom_range(0, 39) == 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_fp_rs1    = 5'($urandom_range(0, 7));
      id_fp_rs2    = 5'($urandom_range(0, 7));
      id_fp_rs3    = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_rd_is_fp  = 1'($urandom);
      id_reg_write = 1'($urandom);
      reset_n      = ($urandom_range(0, 299) != 0);
      cyc();
    end
    reset_n = 1; idle(); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
